// File: rtl/qracc_pkg.sv
// Shared types for the QR compute-in-memory macro: control/status bundles and request opcodes.
package qracc_pkg;

   localparam int unsigned NUM_ROWS   = 128;
   localparam int unsigned NUM_COLS   = 32;
   localparam int unsigned COMP_COUNT = 4;

   localparam logic [1:0] OP_WRITE   = 2'd0;
   localparam logic [1:0] OP_READ    = 2'd1;
   localparam logic [1:0] OP_COMPUTE = 2'd2;
   localparam logic [1:0] OP_RSVD    = 2'd3;

   // Control bundle into the analog macro; every *b field is the complement of its partner.
   typedef struct packed {
      logic [NUM_ROWS-1:0] wl;
      logic                pch;
      logic                write;
      logic [NUM_COLS-1:0] wr_data;
      logic [NUM_COLS-1:0] csel;
      logic                saen;
      logic                clk;
      logic [NUM_ROWS-1:0] vdr_sel;
      logic [NUM_ROWS-1:0] vdr_selb;
      logic [NUM_ROWS-1:0] vss_sel;
      logic [NUM_ROWS-1:0] vss_selb;
      logic [NUM_ROWS-1:0] vrst_sel;
      logic [NUM_ROWS-1:0] vrst_selb;
      logic                nf;
      logic                nfb;
      logic                m2a;
      logic                m2ab;
      logic                r2a;
      logic                r2ab;
   } analog_inputs_t;

   typedef struct packed {
      logic [NUM_COLS-1:0]            sa_out;
      logic [COMP_COUNT*NUM_COLS-1:0] adc_out;
   } analog_outputs_t;

   // Quiescent array: everything off, complement rails high.
   function automatic analog_inputs_t ana_idle();
      analog_inputs_t a;
      a           = '0;
      a.vdr_selb  = '1;
      a.vss_selb  = '1;
      a.vrst_selb = '1;
      a.nfb       = 1'b1;
      a.m2ab      = 1'b1;
      a.r2ab      = 1'b1;
      return a;
   endfunction

endpackage

// File: rtl/qracc_seq_ctrl.sv
// Phase sequencer driving the QR CIM macro for row write, row read and analog MAC compute.
// Optional QRACC_SEQ_PERF_EN adds saturating compute and response-stall counters.
module qracc_seq_ctrl #(
   parameter int unsigned numRows     = 128,
   parameter int unsigned numCols     = 32,
   parameter int unsigned compCount   = 4,
   parameter int unsigned PCH_CYCLES  = 1,
   parameter int unsigned WL_CYCLES   = 2,
   parameter int unsigned RST_CYCLES  = 2,
   parameter int unsigned DRV_CYCLES  = 4,
   parameter int unsigned CONV_CYCLES = 2
) (
   input  logic                              clk,
   input  logic                              nrst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [1:0]                        req_op,
   input  logic [$clog2(numRows)-1:0]        req_row,
   input  logic [numCols-1:0]                req_wdata,
   input  logic [numRows-1:0]                req_act,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic                              rsp_err,
   output logic [compCount*numCols-1:0]      rsp_data,
   output qracc_pkg::analog_inputs_t         ana_ctrl,
   input  qracc_pkg::analog_outputs_t        ana_stat
`ifdef QRACC_SEQ_PERF_EN
   ,
   output logic [15:0]                       perf_compute_cnt,
   output logic [15:0]                       perf_stall_cnt
`endif
);

   import qracc_pkg::*;

   localparam int unsigned ROW_W   = $clog2(numRows);
   localparam int unsigned RSP_W   = compCount * numCols;
   localparam int unsigned MAX_A   = (PCH_CYCLES > WL_CYCLES) ? PCH_CYCLES : WL_CYCLES;
   localparam int unsigned MAX_B   = (RST_CYCLES > DRV_CYCLES) ? RST_CYCLES : DRV_CYCLES;
   localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned MAX_PH  = (MAX_C > CONV_CYCLES) ? MAX_C : CONV_CYCLES;
   localparam int unsigned CNT_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
   localparam bit          ROW_FULL = (numRows == (32'd1 << ROW_W));

   typedef enum logic [2:0] {
      S_IDLE, S_PCH, S_WL, S_SENSE, S_RST, S_DRV, S_CONV, S_RESP
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           op_q, op_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [numCols-1:0]   wdata_q, wdata_d;
   logic [numRows-1:0]   act_q, act_d;
   logic                 req_ready_d;
   logic                 rsp_valid_d;
   logic                 rsp_err_d;
   logic [RSP_W-1:0]     rsp_data_d;
   analog_inputs_t       ctrl_d;
   logic                 accept_c;
   logic                 bad_c;
   logic                 done_c;

   // State, latched request, response and control-bundle registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         row_q     <= '0;
         wdata_q   <= '0;
         act_q     <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         ana_ctrl  <= ana_idle();
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         row_q     <= row_d;
         wdata_q   <= wdata_d;
         act_q     <= act_d;
         req_ready <= req_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_err   <= rsp_err_d;
         rsp_data  <= rsp_data_d;
         ana_ctrl  <= ctrl_d;
      end
   end

   // Next state, phase counter, response capture and next control bundle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      row_d      = row_q;
      wdata_d    = wdata_q;
      act_d      = act_q;
      rsp_err_d  = rsp_err;
      rsp_data_d = rsp_data;
      ctrl_d     = ana_idle();
      accept_c   = 1'b0;
      done_c     = (cnt_q == '0);
      bad_c      = (req_op == OP_RSVD) ||
                   ((req_op != OP_COMPUTE) && !ROW_FULL && (32'(req_row) >= numRows));

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               accept_c   = 1'b1;
               op_d       = req_op;
               row_d      = req_row;
               wdata_d    = req_wdata;
               act_d      = req_act;
               rsp_err_d  = bad_c;
               rsp_data_d = '0;
               if (bad_c)                     state_d = S_RESP;
               else if (req_op == OP_COMPUTE) state_d = S_RST;
               else                           state_d = S_PCH;
            end
         end
         S_PCH:   if (done_c) state_d = S_WL;
         S_WL:    if (done_c) state_d = (op_q == OP_READ) ? S_SENSE : S_RESP;
         S_SENSE: begin
            state_d    = S_RESP;
            rsp_data_d = RSP_W'(ana_stat.sa_out);
         end
         S_RST:   if (done_c) state_d = S_DRV;
         S_DRV:   if (done_c) state_d = S_CONV;
         S_CONV: begin
            if (done_c) begin
               state_d    = S_RESP;
               rsp_data_d = RSP_W'(ana_stat.adc_out);
            end
         end
         S_RESP: begin
            if (rsp_valid && rsp_ready) begin
               state_d    = S_IDLE;
               rsp_err_d  = 1'b0;
               rsp_data_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Reload the shared phase counter on every state entry, else count down to zero.
      if (state_d != state_q) begin
         case (state_d)
            S_PCH:   cnt_d = CNT_W'(PCH_CYCLES - 1);
            S_WL:    cnt_d = CNT_W'(WL_CYCLES - 1);
            S_RST:   cnt_d = CNT_W'(RST_CYCLES - 1);
            S_DRV:   cnt_d = CNT_W'(DRV_CYCLES - 1);
            S_CONV:  cnt_d = CNT_W'(CONV_CYCLES - 1);
            default: cnt_d = '0;
         endcase
      end else if (!done_c) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      // An error response skips one cycle in RESP so its latency matches the accept-to-valid edge.
      req_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RESP) && (state_q != S_IDLE);

      // Control bundle for the state being entered; request data is only used once latched.
      case (state_d)
         S_PCH: ctrl_d.pch = 1'b1;
         S_WL: begin
            ctrl_d.wl[row_q] = 1'b1;
            ctrl_d.csel      = '1;
            if (op_q == OP_WRITE) begin
               ctrl_d.write   = 1'b1;
               ctrl_d.wr_data = wdata_q;
            end
         end
         S_SENSE: begin
            ctrl_d.wl[row_q] = 1'b1;
            ctrl_d.saen      = 1'b1;
            ctrl_d.clk       = 1'b1;
         end
         S_RST: begin
            ctrl_d.vrst_sel = '1;
            ctrl_d.r2a      = 1'b1;
         end
         S_DRV: begin
            ctrl_d.vdr_sel = act_q;
            ctrl_d.vss_sel = ~act_q;
            ctrl_d.nf      = 1'b1;
         end
         S_CONV: begin
            ctrl_d.vdr_sel = act_q;
            ctrl_d.vss_sel = ~act_q;
            ctrl_d.m2a     = 1'b1;
            ctrl_d.clk     = 1'b1;
         end
         default: ;
      endcase

      ctrl_d.vdr_selb  = ~ctrl_d.vdr_sel;
      ctrl_d.vss_selb  = ~ctrl_d.vss_sel;
      ctrl_d.vrst_selb = ~ctrl_d.vrst_sel;
      ctrl_d.nfb       = ~ctrl_d.nf;
      ctrl_d.m2ab      = ~ctrl_d.m2a;
      ctrl_d.r2ab      = ~ctrl_d.r2a;
   end

`ifdef QRACC_SEQ_PERF_EN
   // Saturating counters: accepted computes and cycles a response waits on the consumer.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         perf_compute_cnt <= '0;
         perf_stall_cnt   <= '0;
      end else begin
         if (accept_c && !bad_c && (req_op == OP_COMPUTE) && (perf_compute_cnt != 16'hFFFF))
            perf_compute_cnt <= perf_compute_cnt + 16'd1;
         if (rsp_valid && !rsp_ready && (perf_stall_cnt != 16'hFFFF))
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_qracc_seq_ctrl.sv
// Directed bench for qracc_seq_ctrl with a small analog-macro response model.
module tb_qracc_seq_ctrl;
   import qracc_pkg::*;

   logic                 clk = 1'b0;
   logic                 nrst;
   logic                 req_valid;
   logic                 req_ready;
   logic [1:0]           req_op;
   logic [6:0]           req_row;
   logic [31:0]          req_wdata;
   logic [127:0]         req_act;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_err;
   logic [127:0]         rsp_data;
   analog_inputs_t       ana_ctrl;
   analog_outputs_t      ana_stat;
   logic                 m2a_prev;
`ifdef QRACC_SEQ_PERF_EN
   logic [15:0]          perf_compute_cnt;
   logic [15:0]          perf_stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] SA_VAL = 32'hA5A5_F00F;

   qracc_seq_ctrl dut (
      .clk       (clk),
      .nrst      (nrst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_row   (req_row),
      .req_wdata (req_wdata),
      .req_act   (req_act),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_err   (rsp_err),
      .rsp_data  (rsp_data),
      .ana_ctrl  (ana_ctrl),
      .ana_stat  (ana_stat)
`ifdef QRACC_SEQ_PERF_EN
      ,
      .perf_compute_cnt (perf_compute_cnt),
      .perf_stall_cnt   (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Macro model: SA result only while sensing; ADC result valid only on the 2nd conversion cycle.
   always @(posedge clk) m2a_prev <= ana_ctrl.m2a;
   always_comb begin
      ana_stat.sa_out  = ana_ctrl.saen ? SA_VAL : 32'h0;
      ana_stat.adc_out = (ana_ctrl.m2a && m2a_prev) ? 128'h1234 : 128'hBAD;
   end

   function automatic analog_inputs_t idle_ctrl();
      analog_inputs_t a;
      a           = '0;
      a.vdr_selb  = {128{1'b1}};
      a.vss_selb  = {128{1'b1}};
      a.vrst_selb = {128{1'b1}};
      a.nfb       = 1'b1;
      a.m2ab      = 1'b1;
      a.r2ab      = 1'b1;
      return a;
   endfunction

   // Present one request at a negedge; returns at the negedge after the accept edge (cycle 0).
   task automatic issue(input logic [1:0] op, input logic [6:0] row,
                        input logic [31:0] wd, input logic [127:0] act);
      req_valid = 1'b1;
      req_op    = op;
      req_row   = row;
      req_wdata = wd;
      req_act   = act;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ana_ctrl !== idle_ctrl()) begin
         errors++; $display("FAIL reset_ctrl got=%h exp=%h", ana_ctrl, idle_ctrl());
      end
      checks++;
      if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_data !== 128'h0) begin
         errors++; $display("FAIL reset_rsp got=%b%b%b data=%h exp=000 data=0",
                            req_ready, rsp_valid, rsp_err, rsp_data);
      end
      nrst = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready got=%b exp=1", req_ready);
      end
      // Reset in the middle of a compute drive phase.
      rsp_ready = 1'b1;
      issue(OP_COMPUTE, 7'd0, 32'h0, 128'h0F);
      repeat (3) @(negedge clk);
      checks++;
      if (ana_ctrl.nf !== 1'b1) begin
         errors++; $display("FAIL reset_mid_in_drv nf got=%b exp=1", ana_ctrl.nf);
      end
      nrst = 1'b0;
      #1;
      checks++;
      if (ana_ctrl !== idle_ctrl()) begin
         errors++; $display("FAIL reset_mid_ctrl got=%h exp=%h", ana_ctrl, idle_ctrl());
      end
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
         errors++; $display("FAIL reset_mid_rsp valid=%b ready=%b exp=0 0", rsp_valid, req_ready);
      end
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || ana_ctrl !== idle_ctrl() || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_mid_release ready=%b valid=%b exp ready=1 valid=0 idle ctrl",
                            req_ready, rsp_valid);
      end
   endtask

   task automatic test_write();
      logic [127:0] oh;
      logic         on;
      oh = 128'd1 << 5;
      rsp_ready = 1'b1;
      issue(OP_WRITE, 7'd5, SA_VAL, 128'h0);
      for (int k = 0; k < 5; k++) begin
         on = (k == 1) || (k == 2);
         checks++;
         if (ana_ctrl.pch !== (k == 0)) begin
            errors++; $display("FAIL write_pch cyc=%0d got=%b exp=%b", k, ana_ctrl.pch, (k == 0));
         end
         checks++;
         if (ana_ctrl.wl !== (on ? oh : 128'h0)) begin
            errors++; $display("FAIL write_wl cyc=%0d got=%h exp=%h", k, ana_ctrl.wl, on ? oh : 128'h0);
         end
         checks++;
         if (ana_ctrl.write !== on || ana_ctrl.wr_data !== (on ? SA_VAL : 32'h0) ||
             ana_ctrl.csel !== (on ? 32'hFFFF_FFFF : 32'h0)) begin
            errors++; $display("FAIL write_data cyc=%0d write=%b wr_data=%h csel=%h exp on=%b",
                               k, ana_ctrl.write, ana_ctrl.wr_data, ana_ctrl.csel, on);
         end
         checks++;
         if (rsp_valid !== (k == 3) || req_ready !== (k == 4)) begin
            errors++; $display("FAIL write_hs cyc=%0d valid=%b ready=%b exp=%b %b",
                               k, rsp_valid, req_ready, (k == 3), (k == 4));
         end
         if (k == 3) begin
            checks++;
            if (rsp_data !== 128'h0 || rsp_err !== 1'b0) begin
               errors++; $display("FAIL write_rsp data=%h err=%b exp=0 0", rsp_data, rsp_err);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_read();
      logic [127:0] oh;
      oh = 128'd1 << 5;
      rsp_ready = 1'b1;
      issue(OP_READ, 7'd5, 32'h0, 128'h0);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (ana_ctrl.pch !== (k == 0) || ana_ctrl.write !== 1'b0) begin
            errors++; $display("FAIL read_pch cyc=%0d pch=%b write=%b", k, ana_ctrl.pch, ana_ctrl.write);
         end
         checks++;
         if (ana_ctrl.wl !== ((k >= 1 && k <= 3) ? oh : 128'h0)) begin
            errors++; $display("FAIL read_wl cyc=%0d got=%h", k, ana_ctrl.wl);
         end
         checks++;
         if (ana_ctrl.saen !== (k == 3) || ana_ctrl.clk !== (k == 3)) begin
            errors++; $display("FAIL read_saen cyc=%0d saen=%b clk=%b exp=%b",
                               k, ana_ctrl.saen, ana_ctrl.clk, (k == 3));
         end
         checks++;
         if (rsp_valid !== (k == 4)) begin
            errors++; $display("FAIL read_valid cyc=%0d got=%b exp=%b", k, rsp_valid, (k == 4));
         end
         if (k == 4) begin
            checks++;
            if (rsp_data !== 128'hA5A5_F00F || rsp_err !== 1'b0) begin
               errors++; $display("FAIL read_data got=%h err=%b exp=a5a5f00f 0", rsp_data, rsp_err);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_compute();
      logic [127:0] act;
      logic         rst, drv, conv;
      act = 128'h0F;
      rsp_ready = 1'b1;
      issue(OP_COMPUTE, 7'd0, 32'h0, act);
      for (int k = 0; k < 10; k++) begin
         rst  = (k < 2);
         drv  = (k >= 2) && (k < 6);
         conv = (k == 6) || (k == 7);
         checks++;
         if (ana_ctrl.vrst_sel !== (rst ? {128{1'b1}} : 128'h0) || ana_ctrl.r2a !== rst ||
             ana_ctrl.vrst_selb !== (rst ? 128'h0 : {128{1'b1}}) || ana_ctrl.r2ab !== !rst) begin
            errors++; $display("FAIL comp_rst cyc=%0d vrst=%h r2a=%b r2ab=%b exp rst=%b",
                               k, ana_ctrl.vrst_sel, ana_ctrl.r2a, ana_ctrl.r2ab, rst);
         end
         checks++;
         if (ana_ctrl.vdr_sel !== ((drv || conv) ? act : 128'h0) ||
             ana_ctrl.vss_sel !== ((drv || conv) ? ~act : 128'h0) ||
             ana_ctrl.vdr_selb !== ((drv || conv) ? ~act : {128{1'b1}}) ||
             ana_ctrl.vss_selb !== ((drv || conv) ? act : {128{1'b1}})) begin
            errors++; $display("FAIL comp_sel cyc=%0d vdr=%h vss=%h", k, ana_ctrl.vdr_sel, ana_ctrl.vss_sel);
         end
         checks++;
         if (ana_ctrl.nf !== drv || ana_ctrl.nfb !== !drv || ana_ctrl.m2a !== conv ||
             ana_ctrl.m2ab !== !conv || ana_ctrl.clk !== conv) begin
            errors++; $display("FAIL comp_ctl cyc=%0d nf=%b m2a=%b clk=%b exp nf=%b m2a=%b",
                               k, ana_ctrl.nf, ana_ctrl.m2a, ana_ctrl.clk, drv, conv);
         end
         checks++;
         if (ana_ctrl.wl !== 128'h0 || ana_ctrl.pch !== 1'b0 || rsp_valid !== (k == 8) ||
             req_ready !== (k == 9)) begin
            errors++; $display("FAIL comp_hs cyc=%0d wl=%h pch=%b valid=%b ready=%b",
                               k, ana_ctrl.wl, ana_ctrl.pch, rsp_valid, req_ready);
         end
         if (k == 8) begin
            checks++;
            if (rsp_data !== 128'h1234 || rsp_err !== 1'b0) begin
               errors++; $display("FAIL comp_data got=%h err=%b exp=1234 0", rsp_data, rsp_err);
            end
         end
         @(negedge clk);
      end
   endtask

   // A 7-bit row can never reach numRows=128, so the reserved opcode is the reachable error.
   task automatic test_error();
      rsp_ready = 1'b1;
      issue(OP_RSVD, 7'd5, 32'hFFFF_FFFF, 128'hFF);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ana_ctrl !== idle_ctrl()) begin
            errors++; $display("FAIL err_ctrl cyc=%0d wl=%h pch=%b saen=%b",
                               k, ana_ctrl.wl, ana_ctrl.pch, ana_ctrl.saen);
         end
         checks++;
         if (rsp_valid !== (k == 1) || req_ready !== (k == 2)) begin
            errors++; $display("FAIL err_hs cyc=%0d valid=%b ready=%b exp=%b %b",
                               k, rsp_valid, req_ready, (k == 1), (k == 2));
         end
         if (k == 1) begin
            checks++;
            if (rsp_err !== 1'b1 || rsp_data !== 128'h0) begin
               errors++; $display("FAIL err_rsp err=%b data=%h exp=1 0", rsp_err, rsp_data);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      issue(OP_COMPUTE, 7'd0, 32'h0, 128'hF0);
      repeat (8) @(negedge clk);
      for (int k = 8; k <= 18; k++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 128'h1234 || req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold cyc=%0d valid=%b data=%h ready=%b exp=1 1234 0",
                               k, rsp_valid, rsp_data, req_ready);
         end
         checks++;
         if (ana_ctrl !== idle_ctrl()) begin
            errors++; $display("FAIL bp_idle cyc=%0d pch=%b wl=%h vdr=%h",
                               k, ana_ctrl.pch, ana_ctrl.wl, ana_ctrl.vdr_sel);
         end
         if (k == 8) begin
            req_valid = 1'b1;
            req_op    = OP_WRITE;
            req_row   = 7'd9;
         end
         if (k == 18) begin
            rsp_ready = 1'b1;
            req_valid = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release valid=%b ready=%b exp=0 1", rsp_valid, req_ready);
      end
`ifdef QRACC_SEQ_PERF_EN
      checks++;
      if (perf_stall_cnt !== 16'd10) begin
         errors++; $display("FAIL perf_stall got=%0d exp=10", perf_stall_cnt);
      end
      checks++;
      if (perf_compute_cnt !== 16'd2) begin
         errors++; $display("FAIL perf_compute got=%0d exp=2", perf_compute_cnt);
      end
`endif
      @(negedge clk);
      checks++;
      if (ana_ctrl.pch !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL bp_stray_req pch=%b ready=%b exp=0 1", ana_ctrl.pch, req_ready);
      end
   endtask

   initial begin
      nrst      = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_row   = 7'd0;
      req_wdata = 32'h0;
      req_act   = 128'h0;
      rsp_ready = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_compute();
      test_error();
      test_backpressure();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
